// File: rtl/mem_arb_if.sv
// mem_arb_if: CPU, DMA and memory-side signals of mem_arbiter (slave = arbiter view).
interface mem_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic [DW-1:0] dma_rdata;
  logic          dma_ack;
  logic          dma_last;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          arb_busy;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_last,
    output dma_rdata, dma_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output arb_busy
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_last,
    input  dma_rdata, dma_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  arb_busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: registered CPU/DMA scheduler for one shared memory; DMA burst lock
// is compiled in when MEM_ARB_DMA_BURST_EN is defined.
module mem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MEM_LAT   = 1,
  parameter int MAX_BURST = 8
) (
  input logic      clk,
  input logic      rst,
  mem_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_e;
  state_e        state_q, state_d;
  logic          own_q, own_d, last_q, last_d, we_q, we_d, pick_dma;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, cpu_rd_q, cpu_rd_d, dma_rd_q, dma_rd_d;
  logic [3:0]    lat_q, lat_d;
`ifdef MEM_ARB_DMA_BURST_EN
  logic          lock_q, lock_d;
  logic [7:0]    beat_q, beat_d, beat_n;
  assign beat_n   = beat_q + 8'd1;
  assign pick_dma = bus.dma_req & (lock_q | ~bus.cpu_req | ~last_q);
`else
  assign pick_dma = bus.dma_req & (~bus.cpu_req | ~last_q);
`endif
  // own/last: 1 = DMA, 0 = CPU
  always_comb begin
    state_d  = state_q;
    own_d    = own_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    lat_d    = lat_q;
    cpu_rd_d = cpu_rd_q;
    dma_rd_d = dma_rd_q;
`ifdef MEM_ARB_DMA_BURST_EN
    lock_d   = lock_q;
    beat_d   = beat_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef MEM_ARB_DMA_BURST_EN
        if (!bus.dma_req) begin
          lock_d = 1'b0;
          beat_d = '0;
        end
`endif
        if (bus.cpu_req || bus.dma_req) begin
          state_d = ISSUE;
          own_d   = pick_dma;
          we_d    = pick_dma ? bus.dma_we : bus.cpu_we;
          addr_d  = pick_dma ? bus.dma_addr : bus.cpu_addr;
          wdata_d = pick_dma ? bus.dma_wdata : bus.cpu_wdata;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        lat_d   = 4'(MEM_LAT - 1);
      end
      WAIT: begin
        lat_d = (lat_q == '0) ? lat_q : lat_q - 4'd1;
        if (lat_q == '0) begin
          state_d  = ACK;
          cpu_rd_d = own_q ? cpu_rd_q : bus.mem_rdata;
          dma_rd_d = own_q ? bus.mem_rdata : dma_rd_q;
        end
      end
      ACK: begin
        state_d = IDLE;
        last_d  = own_q;
`ifdef MEM_ARB_DMA_BURST_EN
        if (own_q) begin
          lock_d = ~bus.dma_last & (beat_n != 8'(MAX_BURST));
          beat_d = lock_d ? beat_n : '0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      own_q    <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      lat_q    <= '0;
      cpu_rd_q <= '0;
      dma_rd_q <= '0;
`ifdef MEM_ARB_DMA_BURST_EN
      lock_q   <= 1'b0;
      beat_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      lat_q    <= lat_d;
      cpu_rd_q <= cpu_rd_d;
      dma_rd_q <= dma_rd_d;
`ifdef MEM_ARB_DMA_BURST_EN
      lock_q   <= lock_d;
      beat_q   <= beat_d;
`endif
    end
  end
  assign bus.mem_en    = state_q == ISSUE;
  assign bus.mem_we    = (state_q == ISSUE) & we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_ack   = (state_q == ACK) & ~own_q;
  assign bus.dma_ack   = (state_q == ACK) & own_q;
  assign bus.cpu_rdata = cpu_rd_q;
  assign bus.dma_rdata = dma_rd_q;
  assign bus.arb_busy  = state_q != IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a latency-exact memory model.
module tb_mem_arbiter;
  localparam int LAT  = 3;
  localparam int MAXB = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  always #5 clk = ~clk;
  mem_arb_if #(.AW(32), .DW(32)) bus ();
  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT), .MAX_BURST(MAXB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  // memory: data looked up at the mem_en cycle, valid only exactly LAT cycles later
  logic [31:0] wmem [logic [31:0]];
  logic [LAT-1:0] pv;
  logic [31:0] pd [LAT];
  function automatic logic [31:0] lookup(input logic [31:0] a);
    if (wmem.exists(a)) return wmem[a];
    return (a == 32'h40) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
  endfunction
  always @(posedge clk) begin
    pv <= {pv[LAT-2:0], bus.mem_en};
    pd[0] <= lookup(bus.mem_addr);
    for (int k = LAT - 1; k > 0; k--) pd[k] <= pd[k-1];
    if (bus.mem_en === 1'b1 && bus.mem_we === 1'b1) wmem[bus.mem_addr] = bus.mem_wdata;
  end
  assign bus.mem_rdata = (pv[LAT-1] === 1'b1) ? pd[LAT-1] : 32'hBAD0_BAD0;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic txn(input bit dma, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input string tag);
    if (dma) begin
      bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_addr = addr; bus.dma_wdata = wd; bus.dma_last = 1'b1;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
    end
    for (int k = 1; k <= LAT + 2; k++) begin
      tick();
      check($sformatf("%s.en%0d", tag, k), 32'(bus.mem_en), 32'(k == 1));
      check($sformatf("%s.we%0d", tag, k), 32'(bus.mem_we), 32'(k == 1 && we));
      if (k == 1) check({tag, ".addr"}, bus.mem_addr, addr);
      if (k == 1 && we) check({tag, ".wdata"}, bus.mem_wdata, wd);
      check($sformatf("%s.cack%0d", tag, k), 32'(bus.cpu_ack), 32'(!dma && k == LAT + 2));
      check($sformatf("%s.dack%0d", tag, k), 32'(bus.dma_ack), 32'(dma && k == LAT + 2));
    end
    if (!we) check({tag, ".rdata"}, dma ? bus.dma_rdata : bus.cpu_rdata, exp_rd);
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    tick();
    check({tag, ".idle"}, 32'(bus.arb_busy), 32'd0);
  endtask
  task automatic run_seq(input string name, input string exp);
    int n = 0;
    int last_c = 0;
    bit prev = 1'b0;
    logic [7:0] got;
    for (int c = 0; c < 300 && n < exp.len(); c++) begin
      tick();
      if (prev) check({name, ".idle"}, 32'(bus.arb_busy), 32'd0);
      prev = bus.cpu_ack | bus.dma_ack;
      if (prev) begin
        got = bus.dma_ack ? "D" : "C";
        check($sformatf("%s.who%0d", name, n), 32'(got), 32'(exp[n]));
        check($sformatf("%s.rd%0d", name, n), bus.dma_ack ? bus.dma_rdata : bus.cpu_rdata,
              bus.dma_ack ? 32'h5A5A_0080 : 32'hDEAD_BEEF);
        if (n > 0) check($sformatf("%s.gap%0d", name, n), 32'(c - last_c), 32'(LAT + 3));
        last_c = c;
        n++;
      end
    end
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    check({name, ".count"}, 32'(n), 32'(exp.len()));
    tick();
    check({name, ".end_idle"}, 32'(bus.arb_busy), 32'd0);
  endtask
  initial begin
    bit seen;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0; bus.dma_last = 1'b1;
    tick();
    tick();
    check("rst.en", 32'(bus.mem_en), 32'd0);
    check("rst.we", 32'(bus.mem_we), 32'd0);
    check("rst.addr", bus.mem_addr, 32'd0);
    check("rst.wdata", bus.mem_wdata, 32'd0);
    check("rst.acks", {30'd0, bus.cpu_ack, bus.dma_ack}, 32'd0);
    check("rst.crd", bus.cpu_rdata, 32'd0);
    check("rst.drd", bus.dma_rdata, 32'd0);
    check("rst.busy", 32'(bus.arb_busy), 32'd0);
    rst = 1'b0;
    tick();
    txn(1'b0, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, "rd40");
    txn(1'b0, 1'b1, 32'h10, 32'h1234, 32'h0, "wr10");
    txn(1'b0, 1'b0, 32'h10, 32'h0, 32'h1234, "rd10");
    txn(1'b1, 1'b0, 32'h80, 32'h0, 32'h5A5A_0080, "dma80");
    check("dma80.crd_kept", bus.cpu_rdata, 32'h1234);
    // both requesters held: CPU wins the first tie, then strict alternation
    do_reset();
    bus.cpu_we = 1'b0; bus.cpu_addr = 32'h40; bus.dma_we = 1'b0; bus.dma_addr = 32'h80; bus.dma_last = 1'b1;
    bus.cpu_req = 1'b1; bus.dma_req = 1'b1;
    run_seq("alt", "CDCD");
    do_reset();
    bus.dma_last = 1'b0;
    bus.cpu_req = 1'b1; bus.dma_req = 1'b1;
`ifdef MEM_ARB_DMA_BURST_EN
    run_seq("burst", "CDDDDCDD");
`else
    run_seq("burst", "CDCDCDCDCDCD");
`endif
    bus.dma_last = 1'b1;
    // reset while in WAIT aborts the access
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h44;
    tick();
    check("abort.en", 32'(bus.mem_en), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    check("abort.en_rst", 32'(bus.mem_en), 32'd0);
    check("abort.busy", 32'(bus.arb_busy), 32'd0);
    check("abort.acks", {30'd0, bus.cpu_ack, bus.dma_ack}, 32'd0);
    check("abort.crd", bus.cpu_rdata, 32'd0);
    check("abort.addr", bus.mem_addr, 32'd0);
    rst = 1'b0;
    bus.cpu_req = 1'b0;
    for (int k = 0; k < LAT + 3; k++) begin
      tick();
      check($sformatf("abort.noack%0d", k), {30'd0, bus.cpu_ack, bus.dma_ack}, 32'd0);
    end
    txn(1'b0, 1'b0, 32'h44, 32'h0, 32'h5A5A_0044, "post");
    // CPU drops its request mid-WAIT: the access still completes once
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h48;
    tick();
    tick();
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h84; bus.dma_last = 1'b1;
    for (int k = 3; k <= LAT + 2; k++) begin
      tick();
      check($sformatf("drop.cack%0d", k), 32'(bus.cpu_ack), 32'(k == LAT + 2));
      check($sformatf("drop.dack%0d", k), 32'(bus.dma_ack), 32'd0);
    end
    check("drop.crd", bus.cpu_rdata, 32'h5A5A_0048);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      check($sformatf("drop.no_cack%0d", c), 32'(bus.cpu_ack), 32'd0);
      seen = bus.dma_ack;
    end
    check("drop.dma_granted", 32'(seen), 32'd1);
    check("drop.drd", bus.dma_rdata, 32'h5A5A_0084);
    bus.dma_req = 1'b0;
    tick();
    check("drop.idle", 32'(bus.arb_busy), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, want summary before 300000");
    $fatal(1);
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single unified instruction/data memory between the multi-cycle CPU (fetch and lw/sw accesses) and a DMA/loader requester. It is a registered request/acknowledge scheduler:
- latches the winning request;
- issues exactly one memory access;
- waits a fixed memory latency;
- returns read data with a one-cycle acknowledge.

The CPU control unit holds its current state until `cpu_ack`.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `MEM_LAT`, 1, cycles from the `mem_en` cycle to `mem_rdata` valid; legal range 1..15
- `MAX_BURST`, 8, maximum consecutive DMA beats under burst lock; legal range 2..255

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock; all logic on the rising edge
- `rst` in 1: synchronous, active-high reset
- `cpu_req` in 1: CPU access request; held with its fields until `cpu_ack`
- `cpu_we` in 1: 1 = write
- `cpu_addr` in AW
- `cpu_wdata` in DW
- `cpu_rdata` out DW: registered read data, valid while `cpu_ack`=1
- `cpu_ack` out 1: one-cycle completion pulse
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_rdata`, `dma_ack`: same as the CPU set
- `dma_last` in 1: final beat of a DMA burst
- `mem_en` out 1: memory access strobe, one cycle per transaction
- `mem_we` out 1
- `mem_addr` out AW
- `mem_wdata` out DW
- `mem_rdata` in DW
- `arb_busy` out 1: high whenever the state is not IDLE

## Operation
- States:
  - IDLE
  - ISSUE
  - WAIT (down-counter `lat_cnt`, 4 bits)
  - ACK
- IDLE:
  - If neither request is asserted, stay in IDLE.
  - Otherwise select an owner, latch its `we`/`addr`/`wdata`, and go to ISSUE.
- Selection:
  - Only one requester asserted: that requester wins.
  - Both asserted: the requester not granted last (`last_grant`) wins.
  - Burst lock overrides both rules (see Configuration).
- ISSUE:
  - `mem_en`=1 and `mem_we`=latched `we`; `mem_addr`/`mem_wdata` driven from the latches.
  - Load `lat_cnt`=MEM_LAT-1.
  - Go to WAIT, or directly to ACK-capture when MEM_LAT=1.
- WAIT:
  - Decrement `lat_cnt`.
  - When `lat_cnt` reaches 0, capture `mem_rdata` into the owner's rdata register and go to ACK.
- ACK:
  - Assert `<owner>_ack`=1 for exactly one cycle; the other rdata register is unchanged.
  - Update `last_grant`=owner, then go to IDLE.
- Writes follow the same path. The rdata capture still occurs and its value is don't-care for writes.
- A requester must deassert `req`, or present a new request, in the cycle after `ack`; `req` sampled in IDLE is always treated as new.
- If `req` is dropped before `ack` (protocol violation), the latched transaction still completes and is acked.
- `mem_en`/`mem_we` are never asserted outside ISSUE.

## Timing
- Request-to-ack latency is MEM_LAT+2 cycles:
  - `req` seen in IDLE at cycle t;
  - `mem_en` at t+1;
  - `mem_rdata` sampled at t+1+MEM_LAT;
  - `ack` and rdata at t+2+MEM_LAT.
- Back-to-back throughput is one transaction per MEM_LAT+3 cycles; the IDLE cycle is mandatory.
- Reset values:
  - state IDLE, `lat_cnt`=0, beat counter 0;
  - `last_grant`=DMA, so the CPU wins the first tie;
  - `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0;
  - both acks 0, both rdata 0, `arb_busy`=0.
- Reset asserted mid-transaction aborts it immediately. No ack is issued, and `mem_en` is low in the cycle after reset is sampled.
- A requester whose request is pending is never starved: worst-case wait is one other transaction, or one full burst when burst lock is compiled in.

## Configuration
- Macro `MEM_ARB_DMA_BURST_EN`.
- Defined:
  - An 8-bit beat counter counts DMA beats.
  - After a DMA ACK with `dma_last`=0, the lock stays set and the next IDLE grants DMA even when `cpu_req`=1, provided `dma_req`=1.
  - The lock clears when any of these occurs:
    - a DMA beat is acked with `dma_last`=1;
    - IDLE is reached with `dma_req`=0;
    - MAX_BURST beats have completed.
  - When the lock clears, the beat counter returns to 0.
- Undefined:
  - `dma_last` is ignored and pure round-robin applies to every transaction.
  - No beat counter is synthesized.

## Test plan
- Single CPU read, MEM_LAT=1, memory model returns 0xDEADBEEF for addr 0x40: `mem_en` is high 1 cycle after `req`; `cpu_ack` pulses at t+3 with `cpu_rdata`=0xDEADBEEF; `dma_ack` stays 0.
- CPU write addr 0x10 data 0x1234, MEM_LAT=3: `mem_en`=`mem_we`=1 for exactly one cycle with 0x10/0x1234; `cpu_ack` at t+5.
- `cpu_req` and `dma_req` both held high from reset release, burst lock undefined: grants alternate CPU, DMA, CPU, DMA; each transaction is separated by one IDLE cycle.
- Burst lock defined, MAX_BURST=4, DMA burst of 6 with `dma_last`=0 and `cpu_req` high throughout: DMA is acked 4 times, then the CPU is granted, then the DMA resumes.
- `rst` pulsed during WAIT with MEM_LAT=4: no ack is issued; all outputs return to reset values next cycle; a subsequent CPU request completes normally.
- `cpu_req` dropped in WAIT: `cpu_ack` still pulses once, and the next IDLE grants only an asserted request.
